reg_writeback_unit: RTL

- Write-side front end of the register file. It merges results from the single-cycle ALU path and the variable-latency load path into the one register-file write port.
- Presents RDaddr_o/RDdata_o/RegWrite_o directly to the register-file write inputs.
- Buffers colliding results in order in a small FIFO.
- Exposes a forwarding lookup so decode can read values that are still pending.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 75 +++++++
 rtl/reg_writeback_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
// Contents:
//   DATA_W, ADDR_W - register data and address widths
//   ZERO_REG       - the hard-wired zero register; writes to it are discarded
//   wb_entry_t     - one pending register write {addr, data}
//   is_zero_reg    - true when an address targets ZERO_REG
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO for the write-back unit.
// Accepts up to two pushes and one pop per cycle. It also exposes every slot
// in age order (index 0 = oldest) with a valid mask, which the forwarding
// search uses.
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   push0_i / push0_entry_i   - first (older) push of the cycle
//   push1_i / push1_entry_i   - second (younger) push of the cycle
//   pop_i                     - remove the head entry; never asserted when empty
//   head_o                    - oldest entry (meaningful when count_o != 0)
//   count_o                   - number of valid entries, 0..DEPTH
//   view_o / view_valid_o     - age-ordered snapshot of all slots
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push0_i,
  input  wb_entry_t             push0_entry_i,
  input  logic                  push1_i,
  input  wb_entry_t             push1_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CNT_W-1:0]      count_o,
  output wb_entry_t [DEPTH-1:0] view_o,
  output logic [DEPTH-1:0]      view_valid_o
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_second;
  logic [CNT_W-1:0] count;

  // The second push lands after the first one. If only the second port is
  // used, it writes the current tail slot.
  assign wr_ptr_second = wr_ptr + PTR_W'(push0_i);

  // NOTE: storage is deliberately not reset. Validity comes only from the
  // pointers and count, so clearing the array would add reset fan-out to
  // every bit and buy nothing.
  always_ff @(posedge clk_i) begin
    if (push0_i) mem[wr_ptr]        <= push0_entry_i;
    if (push1_i) mem[wr_ptr_second] <= push1_entry_i;
  end

  // Pointers wrap naturally at DEPTH (a power of 2). The count carries one
  // extra bit so that full and empty can be told apart.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_i);
      wr_ptr <= wr_ptr + PTR_W'(push0_i) + PTR_W'(push1_i);
      count  <= count + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view_o[i]       = mem[rd_ptr + PTR_W'(i)];
      view_valid_o[i] = CNT_W'(i) < count;
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side front end of the register file.
// Merges single-cycle ALU results and variable-latency load results into the
// single register-file write port. Program order is preserved: each cycle the
// oldest candidate (FIFO head, then the accepted load, then the ALU) is
// issued, and the rest are queued. The forwarding port reports the youngest
// write that is still pending.
// Ports:
//   clk_i, rst_i                          - clock, synchronous active-high reset
//   alu_valid_i/alu_addr_i/alu_data_i     - ALU result, always accepted
//   mem_valid_i/mem_ready_o               - load handshake
//   mem_addr_i/mem_data_i                 - load result
//   RDaddr_o/RDdata_o/RegWrite_o          - registered register-file write port
//   fwd_addr_i/fwd_hit_o/fwd_data_o       - combinational forwarding lookup
module reg_writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic              RegWrite_o,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t             fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  wb_entry_t [DEPTH-1:0] fifo_view;
  logic [DEPTH-1:0]      fifo_view_valid;

  logic      fifo_pop;
  logic      push0;
  logic      push1;
  wb_entry_t push0_entry;
  wb_entry_t push1_entry;

  logic      issue;
  wb_entry_t issue_entry;

  wb_entry_t alu_entry;
  wb_entry_t mem_entry;
  logic      mem_take;
  logic      mem_live;
  logic      alu_live;

  // Loads are refused only when the FIFO is full. Worst case per cycle is
  // two pushes and one pop, so at count <= DEPTH-1 the ALU always fits.
  assign mem_ready_o = fifo_count != CNT_W'(DEPTH);
  assign mem_take    = mem_valid_i && mem_ready_o;

  // A write to the zero register completes its handshake, but it is dropped here.
  assign mem_live = mem_take && !is_zero_reg(mem_addr_i);
  assign alu_live = alu_valid_i && !is_zero_reg(alu_addr_i);

  assign alu_entry = '{addr: alu_addr_i, data: alu_data_i};
  assign mem_entry = '{addr: mem_addr_i, data: mem_data_i};

  // Arbitration, oldest first: FIFO head, then load, then ALU. The oldest
  // candidate is issued and the survivors are pushed in age order.
  // NOTE: every signal gets a default at the top of the block so that no
  // path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    issue       = 1'b0;
    issue_entry = '0;
    fifo_pop    = 1'b0;
    push0       = 1'b0;
    push0_entry = alu_entry;
    push1       = 1'b0;
    push1_entry = alu_entry;
    if (fifo_count != '0) begin
      issue       = 1'b1;
      issue_entry = fifo_head;
      fifo_pop    = 1'b1;
      if (mem_live) begin
        push0       = 1'b1;
        push0_entry = mem_entry;
        push1       = alu_live;
      end else begin
        push0 = alu_live;
      end
    end else if (mem_live) begin
      issue       = 1'b1;
      issue_entry = mem_entry;
      push0       = alu_live;
    end else if (alu_live) begin
      issue       = 1'b1;
      issue_entry = alu_entry;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push0_i       (push0),
    .push0_entry_i (push0_entry),
    .push1_i       (push1),
    .push1_entry_i (push1_entry),
    .pop_i         (fifo_pop),
    .head_o        (fifo_head),
    .count_o       (fifo_count),
    .view_o        (fifo_view),
    .view_valid_o  (fifo_view_valid)
  );

  // Output register. Address and data hold their values when idle.
  // NOTE: state registers use non-blocking assignment, so every flop samples
  // pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else begin
      RegWrite_o <= issue;
      if (issue) begin
        RDaddr_o <= issue_entry.addr;
        RDdata_o <= issue_entry.data;
      end
    end
  end

  // Forwarding. The output register is the oldest pending write, and FIFO
  // slots follow in age order. Scanning oldest to youngest with overwrite
  // therefore leaves the youngest match.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    if (!is_zero_reg(fwd_addr_i)) begin
      if (RegWrite_o && RDaddr_o == fwd_addr_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = RDdata_o;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_view_valid[i] && fifo_view[i].addr == fwd_addr_i) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = fifo_view[i].data;
        end
      end
    end
  end

endmodule
